// File: rtl/func_pkg.sv
// Shared definitions for the truth-table scanner: FSM state encoding and the
// default golden table for the 4-input function under test.
package func_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [15:0] EXPECTED_DEFAULT = 16'h754B;

endpackage

// File: rtl/func_scanner.sv
// Walks all 16 input vectors of a 4-input function, holds each for SETTLE_CYC
// cycles, samples the response and compares the captured table to EXPECTED.
module func_scanner
  import func_pkg::*;
#(
  parameter int          SETTLE_CYC = 1,
  parameter logic [15:0] EXPECTED   = EXPECTED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f_in,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic        pass,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t      state, state_nx;
  logic [3:0]  idx, idx_nx;
  logic [3:0]  settle, settle_nx;
  logic [3:0]  vec;
  logic [15:0] table_nx;
  logic [4:0]  mm_nx;
  logic [3:0]  ff_nx;
  logic        pass_nx, busy_nx, done_nx;
  logic        miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    settle_nx = settle;
    table_nx  = table_out;
    mm_nx     = mismatch_cnt;
    ff_nx     = first_fail;
    pass_nx   = pass;
    busy_nx   = busy;
    done_nx   = 1'b0;
    miss      = f_in ^ EXPECTED[idx];
    case (state)
      IDLE: begin
        if (start) begin
          state_nx  = DRIVE;
          idx_nx    = 4'd0;
          settle_nx = 4'd0;
          table_nx  = 16'd0;
          mm_nx     = 5'd0;
          ff_nx     = 4'd0;
          pass_nx   = 1'b0;
          busy_nx   = 1'b1;
        end
      end
      DRIVE: begin
        if (settle == SETTLE_LAST) begin
          settle_nx = 4'd0;
          state_nx  = SAMPLE;
        end else begin
          settle_nx = settle + 4'd1;
        end
      end
      SAMPLE: begin
        table_nx[idx] = f_in;
        if (miss) begin
          mm_nx = mismatch_cnt + 5'd1;
          if (mismatch_cnt == 5'd0) ff_nx = idx;
        end
        // pass is registered on entry to FINISH so it is already valid while done is high
        if (idx == 4'd15) begin
          state_nx = FINISH;
          done_nx  = 1'b1;
          pass_nx  = (table_nx == EXPECTED);
        end else begin
          idx_nx   = idx + 4'd1;
          state_nx = DRIVE;
        end
      end
      FINISH: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= 4'd0;
      settle       <= 4'd0;
      vec          <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      table_out    <= 16'd0;
      mismatch_cnt <= 5'd0;
      first_fail   <= 4'd0;
      pass         <= 1'b0;
    end else begin
      idx          <= idx_nx;
      settle       <= settle_nx;
      vec          <= busy_nx ? idx_nx : 4'd0;
      busy         <= busy_nx;
      done         <= done_nx;
      table_out    <= table_nx;
      mismatch_cnt <= mm_nx;
      first_fail   <= ff_nx;
      pass         <= pass_nx;
    end
  end

  assign {A, B, C, D} = vec;

endmodule

// File: tb/tb_func_scanner.sv
// Directed bench for func_scanner: golden, faulty, stuck-at-0 and delayed
// functions, repeated starts, start in the done cycle and mid-scan reset.
module tb_func_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int mode       = 0;

  // instance 1: SETTLE_CYC=1, combinational function selected by mode
  logic        start1 = 1'b0;
  logic        f_in1;
  logic        a1, b1, c1, d1, busy1, done1, pass1;
  logic [15:0] table1;
  logic [4:0]  mm1;
  logic [3:0]  ff1;
  logic [3:0]  v1;

  // instance 2: SETTLE_CYC=3, golden function delayed by two registers
  logic        start2 = 1'b0;
  logic        f_in2;
  logic        a2, b2, c2, d2, busy2, done2, pass2;
  logic [15:0] table2;
  logic [4:0]  mm2;
  logic [3:0]  ff2;
  logic        dly1, dly2;

  int dcnt1 = 0;

  function automatic logic gold(input logic [3:0] v);
    logic [15:0] t;
    t = 16'h754B;
    return t[v];
  endfunction

  assign v1    = {a1, b1, c1, d1};
  assign f_in1 = (mode == 0) ? gold(v1) :
                 (mode == 1) ? (gold(v1) ^ ((v1 == 4'd3) || (v1 == 4'd9))) : 1'b0;

  always @(posedge clk) begin
    dly1 <= gold({a2, b2, c2, d2});
    dly2 <= dly1;
  end
  assign f_in2 = dly2;

  always @(posedge clk) if (done1 === 1'b1) dcnt1 <= dcnt1 + 1;

  func_scanner #(.SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .f_in(f_in1),
    .A(a1), .B(b1), .C(c1), .D(d1),
    .busy(busy1), .done(done1), .table_out(table1), .pass(pass1),
    .mismatch_cnt(mm1), .first_fail(ff1)
  );

  func_scanner #(.SETTLE_CYC(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .f_in(f_in2),
    .A(a2), .B(b2), .C(c2), .D(d2),
    .busy(busy2), .done(done2), .table_out(table2), .pass(pass2),
    .mismatch_cnt(mm2), .first_fail(ff2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done1(output int lat);
    lat = 1;
    while (done1 !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic scan1(output int lat);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_done1(lat);
  endtask

  initial begin
    int lat;
    int d0;
    int steps;

    // reset state
    tick(); tick();
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_table", table1, 0);
    chk("rst_mm", mm1, 0);
    chk("rst_ff", ff1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_vec", v1, 0);
    rst = 1'b0;
    tick();

    // golden scan
    mode = 0;
    scan1(lat);
    chk("gold_latency", lat, 33);
    chk("gold_table", table1, 16'h754B);
    chk("gold_pass", pass1, 1);
    chk("gold_mm", mm1, 0);
    chk("gold_busy_in_done", busy1, 1);
    chk("gold_vec_in_done", v1, 15);

    // start during the done cycle is ignored, the next IDLE cycle accepts it
    start1 = 1'b1;
    tick();
    chk("done_start_busy", busy1, 0);
    chk("done_start_done", done1, 0);
    chk("done_start_vec", v1, 0);
    chk("idle_table_hold", table1, 16'h754B);
    chk("idle_pass_hold", pass1, 1);
    tick();
    start1 = 1'b0;
    chk("restart_busy", busy1, 1);
    chk("restart_table_clr", table1, 0);
    chk("restart_pass_clr", pass1, 0);
    wait_done1(lat);
    chk("restart_latency", lat, 33);
    chk("restart_table", table1, 16'h754B);
    tick(); tick(); tick();
    chk("idle_stable_table", table1, 16'h754B);
    chk("idle_stable_pass", pass1, 1);

    // faulty function: vectors 3 and 9 inverted
    mode = 1;
    scan1(lat);
    chk("fault_latency", lat, 33);
    chk("fault_table", table1, 16'h7743);
    chk("fault_mm", mm1, 2);
    chk("fault_ff", ff1, 3);
    chk("fault_pass", pass1, 0);
    tick(); tick();

    // f_in stuck at 0
    mode = 2;
    scan1(lat);
    chk("zero_table", table1, 16'h0000);
    chk("zero_mm", mm1, 9);
    chk("zero_ff", ff1, 0);
    chk("zero_pass", pass1, 0);
    tick(); tick();

    // repeated start pulses inside a scan
    mode = 0;
    d0 = dcnt1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    lat = 1;
    while (done1 !== 1'b1 && lat < 200) begin
      start1 = (lat == 5) || (lat == 20);
      tick();
      lat++;
    end
    start1 = 1'b0;
    chk("rep_latency", lat, 33);
    chk("rep_table", table1, 16'h754B);
    chk("rep_pass", pass1, 1);
    for (int i = 0; i < 40; i++) tick();
    chk("rep_done_count", dcnt1 - d0, 1);
    chk("rep_idle_busy", busy1, 0);

    // asynchronous reset mid-scan at idx 7
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    steps = 0;
    while (v1 !== 4'd7 && steps < 100) begin
      tick();
      steps++;
    end
    chk("abort_reached_idx7", v1, 7);
    d0 = dcnt1;
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy1, 0);
    chk("abort_vec", v1, 0);
    chk("abort_table", table1, 0);
    chk("abort_mm", mm1, 0);
    chk("abort_ff", ff1, 0);
    chk("abort_pass", pass1, 0);
    tick(); tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("abort_no_done", dcnt1 - d0, 0);
    chk("abort_stays_idle", busy1, 0);
    scan1(lat);
    chk("post_abort_latency", lat, 33);
    chk("post_abort_table", table1, 16'h754B);
    chk("post_abort_pass", pass1, 1);

    // SETTLE_CYC=3 with a two-cycle-delayed golden function
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    lat = 1;
    while (done2 !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
    chk("slow_latency", lat, 65);
    chk("slow_pass", pass2, 1);
    chk("slow_table", table2, 16'h754B);
    chk("slow_mm", mm2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
